// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared bus: registered one-hot grant held while the
// owner keeps requesting, one dead turnaround cycle between owners, optional preemption.
module rr_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_req
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] PARK  = 2'd2;

  // The hold counter only needs to reach MAX_HOLD-1, where it saturates.
  localparam int             HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [HC_W-1:0] hold_cnt;

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;
  logic [NREQ-1:0] pick_gnt;
  logic [ID_W-1:0] next_ptr;
  logic            competitor;
  logic            release_now;
  logic            preempt;

  assign any_req = |req;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
    pick_gnt          = '0;
    pick_gnt[pick_id] = 1'b1;
  end

  assign next_ptr    = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
  assign competitor  = |(req & ~gnt);
  assign release_now = ~req[gnt_id];
  assign preempt     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && competitor && !lock;

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      case (state)
        IDLE, PARK: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt       <= pick_gnt;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_id;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now || preempt) begin
            state     <= PARK;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_ptr;
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios with literal expectations plus random
// traffic compared every cycle against an owner/pointer/hold-count model.
module tb_rr_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = '0;
  logic       lock  = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       any_req;

  int total = 0;
  int bad   = 0;

  rr_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .any_req   (any_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, where the search starts, and how many cycles the owner has shown gnt.
  // The dead cycle after a release is simply "no owner"; arbitration resumes at the next edge.
  // The owner is preempted once it has held at least MAX_HOLD cycles and preemption is allowed.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cycles = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_cycles = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner[1:0]] ||
          (MAX_HOLD != 0 && m_cycles >= MAX_HOLD && (req & ~(4'b1 << m_owner)) != 4'b0 && !lock)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_cycles++;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req[idx[1:0]]) begin
          m_owner  = idx;
          m_cycles = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("gnt", {28'b0, gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_valid", {31'b0, gnt_valid}, {31'b0, (m_owner >= 0)});
      if (m_owner >= 0) check("gnt_id", {30'b0, gnt_id}, m_owner);
      check("any_req", {31'b0, any_req}, {31'b0, |req});
    end
  end

  // Callers sit at a falling edge; inputs change 1ns later, well away from either edge.
  task automatic set_in(input logic [3:0] r, input logic l);
    #1;
    req  = r;
    lock = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    #1;
    reset = 1'b1;
    req   = '0;
    lock  = 1'b0;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         cnt;
    int         w;
    logic [3:0] oh;
    logic [3:0] r;
    logic [3:0] flip;

    // Reset state
    tick();
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_valid", {31'b0, gnt_valid}, 32'd0);
    check("rst_id", {30'b0, gnt_id}, 32'd0);
    #1 reset = 1'b0;
    tick();

    // 1: lowest index in search order wins after one edge
    set_in(4'b0101, 1'b0);
    tick();
    check("t1_gnt", {28'b0, gnt}, 32'h1);
    check("t1_id", {30'b0, gnt_id}, 32'd0);
    check("t1_valid", {31'b0, gnt_valid}, 32'd1);
    check("t1_any", {31'b0, any_req}, 32'd1);

    // 2: release, one dead cycle, then requester 2
    set_in(4'b0100, 1'b0);
    tick();
    check("t2_dead", {28'b0, gnt}, 32'h0);
    tick();
    check("t2_gnt", {28'b0, gnt}, 32'h4);
    check("t2_id", {30'b0, gnt_id}, 32'd2);
    set_in(4'b0000, 1'b0);
    tick();

    // 3: all requesting, each owner releases after two cycles -> 0,1,2,3,0,1
    do_reset();
    set_in(4'hF, 1'b0);
    for (int k = 0; k < 6; k++) begin
      oh = 4'b1 << (k % 4);
      w  = 0;
      tick();
      while (!gnt_valid && w < 3) begin
        tick();
        w++;
      end
      check("t3_id", {30'b0, gnt_id}, k % 4);
      check("t3_gnt", {28'b0, gnt}, {28'b0, oh});
      tick();
      set_in(4'hF & ~oh, 1'b0);
      tick();
      check("t3_dead", {28'b0, gnt}, 32'h0);
      set_in(4'hF, 1'b0);
    end
    tick();
    set_in(4'h0, 1'b0);
    tick();

    // 4a: preemption after exactly MAX_HOLD cycles
    do_reset();
    set_in(4'b0001, 1'b0);
    tick();
    check("t4_first", {28'b0, gnt}, 32'h1);
    set_in(4'b0011, 1'b0);
    cnt = 1;
    tick();
    while (gnt == 4'b0001 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t4_hold", cnt, MAX_HOLD);
    check("t4_dead", {28'b0, gnt}, 32'h0);
    tick();
    check("t4_next", {28'b0, gnt}, 32'h2);

    // 4b: lock keeps the owner well past MAX_HOLD; dropping lock preempts at the next edge
    do_reset();
    set_in(4'b0001, 1'b1);
    tick();
    set_in(4'b0011, 1'b1);
    cnt = 1;
    tick();
    while (gnt == 4'b0001 && cnt < 60) begin
      cnt++;
      tick();
    end
    check("t4_lock_hold", {31'b0, (cnt >= 40)}, 32'd1);
    set_in(4'b0011, 1'b0);
    tick();
    check("t4_unlock_dead", {28'b0, gnt}, 32'h0);
    tick();
    check("t4_unlock_next", {28'b0, gnt}, 32'h2);

    // 5: single requester never preempted
    do_reset();
    set_in(4'b1000, 1'b0);
    cnt = 0;
    repeat (50) begin
      tick();
      if (gnt == 4'b1000 && gnt_id == 2'd3) cnt++;
    end
    check("t5_hold", cnt, 32'd50);

    // 6: async reset mid-grant clears outputs before any edge; restart from ptr 0
    do_reset();
    set_in(4'b0100, 1'b0);
    tick();
    check("t6_pre", {28'b0, gnt}, 32'h4);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_gnt", {28'b0, gnt}, 32'h0);
    check("t6_rst_valid", {31'b0, gnt_valid}, 32'd0);
    tick();
    #1;
    req   = 4'b1010;
    reset = 1'b0;
    tick();
    check("t6_gnt", {28'b0, gnt}, 32'h2);
    check("t6_id", {30'b0, gnt_id}, 32'd1);

    // Random traffic: requests toggle rarely so owners often reach the hold limit
    do_reset();
    r = '0;
    repeat (3000) begin
      flip = '0;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 23) == 0) flip[b] = 1'b1;
      r = r ^ flip;
      set_in(r, ($urandom_range(0, 3) == 0));
      tick();
    end

    set_in(4'h0, 1'b0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
